sync_fifo_ctrl: RTL

//  Single-clock FIFO built around the dual-port async-read RAM (ram_dp_async_read).

---
 rtl/fifo_pkg.sv | 16 +
 rtl/ram_dp_async_read.sv | 24 ++
 rtl/sync_fifo_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer width, depth check and almost-flag margins.
package fifo_pkg;

    localparam int AF_MARGIN = 1;
    localparam int AE_MARGIN = 1;

    // Pointers carry one bit beyond the RAM address so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_dp_async_read.sv
// Dual-port RAM with a synchronous write port and an asynchronous (combinational) read port.
module ram_dp_async_read #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr_wr,
    input  logic [WIDTH-1:0]         data_wr,
    input  logic [$clog2(DEPTH)-1:0] addr_rd,
    output logic [WIDTH-1:0]         data_rd
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_wr] <= data_wr;
        end
    end

    assign data_rd = mem[addr_rd];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock show-ahead FIFO controller around ram_dp_async_read.
// Define FIFO_LEVEL_EN to add the level, almost_full and almost_empty outputs.
import fifo_pkg::*;

module sync_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG:0] level,
    output logic               almost_full,
    output logic               almost_empty
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Pointers wrap naturally modulo 2*DEPTH; error pulses reflect the request of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    ram_dp_async_read #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .addr_wr (wr_ptr[DEPTH_LOG-1:0]),
        .data_wr (wr_data),
        .addr_rd (rd_ptr[DEPTH_LOG-1:0]),
        .data_rd (rd_data)
    );

`ifdef FIFO_LEVEL_EN
    ptr_t level_next;

    assign level      = wr_ptr - rd_ptr;
    assign level_next = level + ptr_t'(push) - ptr_t'(pop);

    // Flags are registered from the post-edge occupancy so they track level without lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level_next >= ptr_t'(DEPTH - AF_MARGIN));
            almost_empty <= (level_next <= ptr_t'(AE_MARGIN));
        end
    end
`endif

endmodule
